// File: rtl/limber_uart_tx.sv
// limber_uart_tx: UART transmit engine for the Limber MCU.
// Pops bytes from a fall-through TX FIFO and serialises each one LSB first,
// with an optional even/odd parity bit and one or two stop bits.
// All frame settings are captured when the byte is popped, so a frame in
// flight is unaffected by later changes to the configuration inputs.
module limber_uart_tx #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_ren,
  output logic             tx,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state;
  state_t state_next;

  // Frame payload and settings captured at the pop edge.
  logic [7:0]       shreg;
  logic [DIV_W-1:0] div_q;
  logic             par_en_q;
  logic             stop2_q;
  logic             par_q;

  // Bit timing and position within the frame.
  logic [DIV_W-1:0] timer;
  logic [2:0]       bit_cnt;
  logic             stop_cnt;

  // Combinational decode of the current state.
  logic             pop;
  logic             bit_end;
  logic             tx_d;

  // Next-state and line-level decode for the current state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_next = state;
    tx_d       = 1'b1;
    pop        = 1'b0;
    bit_end    = (timer == '0);
    unique case (state)
      S_IDLE: begin
        pop = en & ~fifo_empty;
        if (pop) begin
          state_next = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = shreg[0];
        if (bit_end && (bit_cnt == 3'd7)) begin
          state_next = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        tx_d = par_q;
        if (bit_end) begin
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end && (!stop2_q || stop_cnt)) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // The pop strobe is held low while reset is asserted, even though the
  // state register already reads IDLE then.
  assign fifo_ren = pop & rst;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values regardless of the order the processes are evaluated.
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered line outputs: they follow the state one clock later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx   <= 1'b1;
      busy <= 1'b0;
    end else begin
      tx   <= tx_d;
      busy <= (state != S_IDLE);
    end
  end

  // Frame capture at the pop edge, then bit timing and data shifting.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the payload and settings registers are ordinary flops rather than
    // a memory array, so they are cleared on reset like the control state and
    // the block comes out of reset in a fully known condition.
    if (!rst) begin
      shreg    <= '0;
      div_q    <= '0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      par_q    <= 1'b0;
      timer    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else if (pop) begin
      shreg    <= fifo_dout;
      div_q    <= baud_div;
      par_en_q <= parity_en;
      stop2_q  <= stop2;
      par_q    <= ^fifo_dout ^ parity_odd;
      timer    <= baud_div;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else if (state != S_IDLE) begin
      if (bit_end) begin
        // Reload rather than decrement so the timer never wraps.
        timer <= div_q;
        if (state == S_DATA) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (state == S_STOP) begin
          stop_cnt <= 1'b1;
        end
      end else begin
        timer <= timer - DIV_W'(1);
      end
    end
  end

endmodule
